// File: rtl/tlb_coalescer_pkg.sv
// Shared types and constants for the TLB request coalescer.
package tlb_coalescer_pkg;

  localparam int VADDR_BITS       = 48;
  localparam int LEN_BITS         = 28;
  localparam int DEST_BITS        = 4;
  localparam int STRM_BITS        = 2;
  localparam int CMODE_BITS       = 2;
  localparam int PMTU_BYTES       = 4096;
  localparam int COAL_MAX_LEN_DEF = 16384;
  localparam int COAL_TIMEOUT_DEF = 16;

  // Attributes that must match for two chunks to be merged.
  localparam int ATTR_BITS = CMODE_BITS + 1 + STRM_BITS + DEST_BITS;

  typedef struct packed {
    logic [7:0]            rsrvd_high;
    logic [CMODE_BITS-1:0] cache_mode;
    logic [DEST_BITS-1:0]  dest;
    logic [STRM_BITS-1:0]  stream;
    logic                  sync;
    logic                  ctl;
    logic [LEN_BITS-1:0]   len;
    logic [VADDR_BITS-1:0] vaddr;
    logic [7:0]            rsrvd;
  } req_t;

  // Accumulator contents: a request without the reserved fields.
  typedef struct packed {
    logic [CMODE_BITS-1:0] cache_mode;
    logic [DEST_BITS-1:0]  dest;
    logic [STRM_BITS-1:0]  stream;
    logic                  sync;
    logic                  ctl;
    logic [LEN_BITS-1:0]   len;
    logic [VADDR_BITS-1:0] vaddr;
  } acc_t;

  function automatic acc_t req_to_acc(input req_t r);
    acc_t a;
    a.cache_mode = r.cache_mode;
    a.dest       = r.dest;
    a.stream     = r.stream;
    a.sync       = r.sync;
    a.ctl        = r.ctl;
    a.len        = r.len;
    a.vaddr      = r.vaddr;
    return a;
  endfunction

  // Reserved fields always leave the block as zero.
  function automatic req_t acc_to_req(input acc_t a);
    req_t r;
    r            = '0;
    r.cache_mode = a.cache_mode;
    r.dest       = a.dest;
    r.stream     = a.stream;
    r.sync       = a.sync;
    r.ctl        = a.ctl;
    r.len        = a.len;
    r.vaddr      = a.vaddr;
    return r;
  endfunction

  function automatic logic [ATTR_BITS-1:0] acc_attr(input acc_t a);
    return {a.cache_mode, a.sync, a.stream, a.dest};
  endfunction

endpackage

// File: rtl/tlb_coalescer_if.sv
// Valid/ready request channel carrying one req_t per transfer.
interface tlb_coalescer_if;
  import tlb_coalescer_pkg::*;

  logic valid;
  logic ready;
  req_t req;

  modport m (output valid, output req, input ready);
  modport s (input valid, input req, output ready);

endinterface

// File: rtl/tlb_coalescer_merge_check.sv
// Decides whether an incoming chunk can extend the accumulated request.
// The end address is computed one bit wider so a wrap past the top of the
// address space is seen as a break rather than a match at address 0.
module tlb_coalescer_merge_check
  import tlb_coalescer_pkg::*;
#(
  parameter int MAX_LEN = COAL_MAX_LEN_DEF
) (
  input  logic [VADDR_BITS-1:0] acc_vaddr_i,
  input  logic [LEN_BITS-1:0]   acc_len_i,
  input  logic [ATTR_BITS-1:0]  acc_attr_i,
  input  logic [VADDR_BITS-1:0] in_vaddr_i,
  input  logic [LEN_BITS-1:0]   in_len_i,
  input  logic [ATTR_BITS-1:0]  in_attr_i,
  output logic                  mergeable_o,
  output logic [LEN_BITS-1:0]   sum_len_o,
  output logic                  hits_max_o
);

  localparam logic [LEN_BITS:0] MAX_LEN_W = (LEN_BITS+1)'(MAX_LEN);

  logic [VADDR_BITS:0] acc_end;
  logic [LEN_BITS:0]   sum;
  logic                addr_ok;
  logic                attr_ok;
  logic                fits;

  assign acc_end     = {1'b0, acc_vaddr_i} + (VADDR_BITS+1)'(acc_len_i);
  assign sum         = {1'b0, acc_len_i} + {1'b0, in_len_i};
  assign addr_ok     = ~acc_end[VADDR_BITS] & (acc_end[VADDR_BITS-1:0] == in_vaddr_i);
  assign attr_ok     = (acc_attr_i == in_attr_i);
  assign fits        = (sum <= MAX_LEN_W);
  assign mergeable_o = addr_ok & attr_ok & fits;
  assign sum_len_o   = sum[LEN_BITS-1:0];
  assign hits_max_o  = (sum == MAX_LEN_W);

endmodule

// File: rtl/tlb_coalescer.sv
// Merges a stream of contiguous request chunks into bursts of up to MAX_LEN
// bytes, flushing on a last chunk, the size limit, a break in address or
// attributes, or an idle timeout.
//
//  state    | meaning
//  ST_IDLE  | nothing held; any chunk is accepted as a new accumulator
//  ST_ACCUM | accumulator open; contiguous chunks extend it, idle cycles count
//  ST_SEND  | merged request presented on req_out until accepted
module tlb_coalescer
  import tlb_coalescer_pkg::*;
#(
  parameter int MAX_LEN = COAL_MAX_LEN_DEF,
  parameter int TIMEOUT = COAL_TIMEOUT_DEF
) (
  input  logic       aclk,
  input  logic       areset,
  tlb_coalescer_if.s req_in,
  tlb_coalescer_if.m req_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

  localparam int                  TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]       TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [LEN_BITS-1:0] MAX_LEN_L  = LEN_BITS'(MAX_LEN);

  state_t              state_q;
  acc_t                acc_q;
  logic [TW-1:0]       timer_q;
  logic                out_valid_q;

  acc_t                in_acc;
  logic                merge_ok;
  logic [LEN_BITS-1:0] sum_len;
  logic                hits_max;
  logic                in_big;
  logic                in_ready;

  assign in_acc = req_to_acc(req_in.req);
  assign in_big = (in_acc.len >= MAX_LEN_L);

  tlb_coalescer_merge_check #(
    .MAX_LEN (MAX_LEN)
  ) u_merge_check (
    .acc_vaddr_i (acc_q.vaddr),
    .acc_len_i   (acc_q.len),
    .acc_attr_i  (acc_attr(acc_q)),
    .in_vaddr_i  (in_acc.vaddr),
    .in_len_i    (in_acc.len),
    .in_attr_i   (acc_attr(in_acc)),
    .mergeable_o (merge_ok),
    .sum_len_o   (sum_len),
    .hits_max_o  (hits_max)
  );

  // Input ready: open in IDLE, only for a mergeable chunk in ACCUM, held low in reset.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE:  in_ready = 1'b1;
      ST_ACCUM: in_ready = req_in.valid & merge_ok;
      default:  in_ready = 1'b0;
    endcase
    if (areset) in_ready = 1'b0;
  end

  assign req_in.ready  = in_ready;
  assign req_out.valid = out_valid_q;
  assign req_out.req   = acc_to_req(acc_q);

  // Coalescing FSM with accumulator, idle timer and registered output valid.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      timer_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_in.valid) begin
            acc_q   <= in_acc;
            timer_q <= '0;
            if (in_acc.ctl || in_big) begin
              state_q     <= ST_SEND;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          if (req_in.valid) begin
            timer_q <= '0;
            if (merge_ok) begin
              acc_q.len <= sum_len;
              acc_q.ctl <= in_acc.ctl;
              if (in_acc.ctl || hits_max) begin
                state_q     <= ST_SEND;
                out_valid_q <= 1'b1;
              end
            end else begin
              // Break in contiguity: flush now, the chunk is retried from IDLE.
              state_q     <= ST_SEND;
              out_valid_q <= 1'b1;
            end
          end else if (timer_q == TIMER_LAST) begin
            timer_q     <= '0;
            state_q     <= ST_SEND;
            out_valid_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_SEND: begin
          if (req_out.ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
